xgmm_wr: RTL
============

Name: xgmm_wr

Overview:
- Graphics memory write mover. Sits directly downstream of the graphics register interface (pattern FIFO 16x16, attribute FIFO 4x16) and upstream of the SDRAM controller write port.
- When a FIFO reports full, it drains it into SDRAM as 4-word write bursts.
- Its pop pulses drive the pattern/attribute address registers in the register interface:
  - PAR advances after every 4th pattern pop pulse.
  - AAR advances by 4 after each attribute pop pulse.

Parameters:
PAT_BASE, 24'h000000, SDRAM word address of pattern region
ATTR_BASE, 24'h010000, SDRAM word address of attribute region

Ports:
clk_sys  in  1  system clock
rst  in  1  synchronous active-high reset
p_full  in  1  pattern FIFO holds 16 words
a_full  in  1  attribute FIFO holds 4 words
p_data  in  16  pattern FIFO head (show-ahead)
a_data  in  16  attribute FIFO head (show-ahead)
par  in  12  pattern address register (pattern index)
aar  in  13  attribute address register (word address)
p_pop  out  1  pattern FIFO pop
a_pop  out  1  attribute FIFO pop
mem_req  out  1  write burst request
mem_addr  out  24  burst start word address
mem_ack  in  1  request accepted (1-cycle pulse)
mem_dreq  in  1  controller consumes mem_wdata this cycle
mem_wdata  out  16  write data
busy  out  1  high whenever state != IDLE
proto_err  out  1  sticky: mem_dreq seen outside a data phase

Behaviour:
- Clock and reset: one clock, clk_sys. rst is synchronous, active-high.
  - Reset values: all outputs 0; state IDLE; word_cnt=0, burst_cnt=0, last_srv=ATTR.
  - rst mid-burst aborts immediately: mem_req and pops drop next edge, no further pops. The FIFOs are reset by the same rst.
- States: IDLE, P_REQ, P_DATA, A_REQ, A_DATA.
- IDLE:
  - Only p_full: go to P_REQ with burst_cnt=0, latch pat_idx=par.
  - Only a_full: go to A_REQ, latch attr_addr=aar.
  - Both full: serve opposite of last_srv (round-robin), then update last_srv.
- P_REQ:
  - mem_req=1.
  - mem_addr = PAT_BASE + {pat_idx, burst_cnt, 2'b00}, zero-extended 16-bit offset, modulo 2^24.
  - On mem_ack go to P_DATA with word_cnt=0.
- P_DATA:
  - mem_req=0. p_pop = mem_dreq (combinational). mem_wdata = p_data.
  - Each mem_dreq: word_cnt+1.
  - On 4th dreq:
    - burst_cnt<3: burst_cnt+1, back to P_REQ.
    - burst_cnt=3: go to IDLE.
- A_REQ / A_DATA: same as the pattern path.
  - mem_addr = ATTR_BASE + attr_addr (zero-extended).
  - mem_wdata = a_data, a_pop = mem_dreq.
  - Single burst, then IDLE.
- mem_wdata in all other states: 16'h0000.
- Pop-pulse rule: p_pop/a_pop are always low in REQ/IDLE states. Each 4-word burst therefore forms one pop pulse with a falling edge before the next burst. Register-interface counting relies on this: 4 pulses = 1 PAR increment.
- mem_dreq may be non-contiguous within a burst; the pop pulse may then split. The controller contract requires dreq to be contiguous for exactly 4 cycles; non-contiguous dreq is unsupported but must not corrupt the word count.
- pat_idx / attr_addr latched at service start. PAR/AAR changing mid-service (CPU write, auto-increment) has no effect until the next service.
- mem_ack outside REQ states: ignored.
- mem_dreq in IDLE/REQ states:
  - No pop.
  - proto_err set; cleared only by rst.
- mem_req held until mem_ack, with no timeout; mem_addr stable while mem_req=1.
- A pattern service always moves exactly 16 words (4 bursts), even if p_full drops after start.

Test Plan:
1. Reset: assert rst 2 cycles mid-P_DATA (word_cnt=2) -> next edge mem_req=0, p_pop=0, busy=0, proto_err=0.
2. Pattern drain: par=12'h005, p_full, ack 2 cycles after each req, dreq 4 contiguous cycles -> mem_addr 24'h000050/54/58/5C; 16 pops in 4 pulses; mem_wdata equals FIFO words 0..15 in order.
3. Attribute drain: aar=13'h0108, a_full -> one burst at mem_addr 24'h010108; 4 a_pop cycles; busy falls after 4th dreq.
4. Round-robin: p_full and a_full both high from reset -> pattern serviced first (last_srv=ATTR at reset), then attribute. Refill both -> pattern again.
5. Stalled ack: hold mem_ack low 20 cycles -> mem_req and mem_addr stable, no pops. par changed to 12'h0FF during the stall -> address still uses the latched pat_idx.
6. Protocol error: mem_dreq pulse in IDLE -> no pop, proto_err=1 persists until rst. Edge case: PAT_BASE=24'hFFFFF0, par=12'hFFF -> address wraps modulo 2^24.

Source files
------------

// File: rtl/xgmm_wr.sv
// Graphics memory write mover: drains the full pattern or attribute FIFO into SDRAM
// as 4-word write bursts. A pattern service is 4 bursts; an attribute service is 1 burst.
module xgmm_wr #(
   parameter logic [23:0] PAT_BASE  = 24'h000000,
   parameter logic [23:0] ATTR_BASE = 24'h010000
) (
   input  logic        clk_sys,
   input  logic        rst,
   input  logic        p_full,
   input  logic        a_full,
   input  logic [15:0] p_data,
   input  logic [15:0] a_data,
   input  logic [11:0] par,
   input  logic [12:0] aar,
   output logic        p_pop,
   output logic        a_pop,
   output logic        mem_req,
   output logic [23:0] mem_addr,
   input  logic        mem_ack,
   input  logic        mem_dreq,
   output logic [15:0] mem_wdata,
   output logic        busy,
   output logic        proto_err
);

   typedef enum logic [2:0] {IDLE, P_REQ, P_DATA, A_REQ, A_DATA} state_t;

   localparam logic SRV_PAT  = 1'b0;
   localparam logic SRV_ATTR = 1'b1;

   state_t      r_state;
   state_t      w_nextState;
   logic [11:0] r_patIdx;
   logic [12:0] r_attrAddr;
   logic [1:0]  r_wordCnt;
   logic [1:0]  r_burstCnt;
   logic        r_lastSrv;
   logic        r_protoErr;

   logic        w_inData;
   logic        w_inReq;
   logic        w_lastWord;
   logic        w_startPat;
   logic        w_startAttr;

   assign w_inData   = (r_state == P_DATA) || (r_state == A_DATA);
   assign w_inReq    = (r_state == P_REQ)  || (r_state == A_REQ);
   assign w_lastWord = w_inData && mem_dreq && (r_wordCnt == 2'd3);

   // Round-robin only matters when both FIFOs are full; the side served last yields.
   assign w_startPat  = (r_state == IDLE) && p_full && (!a_full || (r_lastSrv == SRV_ATTR));
   assign w_startAttr = (r_state == IDLE) && a_full && (!p_full || (r_lastSrv == SRV_PAT));

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         r_state    <= IDLE;
         r_patIdx   <= 12'h000;
         r_attrAddr <= 13'h0000;
         r_wordCnt  <= 2'd0;
         r_burstCnt <= 2'd0;
         r_lastSrv  <= SRV_ATTR;
         r_protoErr <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_startPat) begin
            r_patIdx   <= par;
            r_burstCnt <= 2'd0;
            r_lastSrv  <= SRV_PAT;
         end
         if (w_startAttr) begin
            r_attrAddr <= aar;
            r_lastSrv  <= SRV_ATTR;
         end
         if (w_inReq && mem_ack) begin
            r_wordCnt <= 2'd0;
         end
         if (w_inData && mem_dreq) begin
            r_wordCnt <= r_wordCnt + 2'd1;
         end
         if (w_lastWord && (r_state == P_DATA) && (r_burstCnt != 2'd3)) begin
            r_burstCnt <= r_burstCnt + 2'd1;
         end
         if (mem_dreq && !w_inData) begin
            r_protoErr <= 1'b1;
         end
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_startPat) begin
               w_nextState = P_REQ;
            end else if (w_startAttr) begin
               w_nextState = A_REQ;
            end
         end
         P_REQ: begin
            if (mem_ack) begin
               w_nextState = P_DATA;
            end
         end
         P_DATA: begin
            if (w_lastWord) begin
               w_nextState = (r_burstCnt == 2'd3) ? IDLE : P_REQ;
            end
         end
         A_REQ: begin
            if (mem_ack) begin
               w_nextState = A_DATA;
            end
         end
         A_DATA: begin
            if (w_lastWord) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Pops are gated by the data states so every burst is its own pulse for the PAR/AAR counters.
   always_comb begin
      mem_req   = 1'b0;
      mem_addr  = 24'h000000;
      mem_wdata = 16'h0000;
      p_pop     = 1'b0;
      a_pop     = 1'b0;
      case (r_state)
         P_REQ: begin
            mem_req  = 1'b1;
            mem_addr = PAT_BASE + {8'h00, r_patIdx, r_burstCnt, 2'b00};
         end
         P_DATA: begin
            p_pop     = mem_dreq;
            mem_wdata = p_data;
         end
         A_REQ: begin
            mem_req  = 1'b1;
            mem_addr = ATTR_BASE + {11'h000, r_attrAddr};
         end
         A_DATA: begin
            a_pop     = mem_dreq;
            mem_wdata = a_data;
         end
         default: begin
            mem_req = 1'b0;
         end
      endcase
   end

   assign busy      = (r_state != IDLE);
   assign proto_err = r_protoErr;

endmodule
